// File: rtl/ram24_arbiter.sv
// ram24_arbiter: two-client round-robin arbiter and sequencer for a single-port
// 24-bit x 4096 RAM. Commands pass through IDLE -> ACCESS -> DONE, so there is
// one RAM access every 3 cycles at most.
// Ports:
//   clk, RE           clock and synchronous active-high reset
//   req/we/addr/wdata per-client command (A and B), held until grant
//   gnt_a/gnt_b       high during the owner's RAM access cycle
//   done_a/done_b     one-cycle completion pulse; rdata is valid with it for reads
//   ram_addr/ram_din/ram_we  driven to the RAM; ram_dout is its combinational read data
module ram24_arbiter #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          RE,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done_a,
  output logic          done_b,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q;
  logic          owner_q;     // 0 = A, 1 = B
  logic          last_b_q;    // 1 when B was served last; reset value gives A priority
  logic          cmd_we_q;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_din_q;
  logic [DW-1:0] rdata_q;
  logic          gnt_a_q, gnt_b_q;
  logic          done_a_q, done_b_q;
  logic          ram_we_q;

  logic          any_req;
  logic          owner_d;

  // B wins when it is alone, or when both ask and A was the last one served.
  always_comb begin
    any_req = req_a | req_b;
    owner_d = req_b & (~req_a | ~last_b_q);
  end

  always_ff @(posedge clk) begin
    if (RE) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_b_q   <= 1'b1;
      cmd_we_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_din_q  <= '0;
      rdata_q    <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      // Pulsed outputs default low; only the state that owns them raises them.
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      ram_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q    <= ST_ACCESS;
            owner_q    <= owner_d;
            last_b_q   <= owner_d;
            cmd_we_q   <= owner_d ? we_b    : we_a;
            cmd_addr_q <= owner_d ? addr_b  : addr_a;
            cmd_din_q  <= owner_d ? wdata_b : wdata_a;
            ram_we_q   <= owner_d ? we_b    : we_a;
            gnt_a_q    <= ~owner_d;
            gnt_b_q    <= owner_d;
          end
        end
        ST_ACCESS: begin
          // RAM read is combinational, so Dout is already valid for cmd_addr_q.
          if (!cmd_we_q) rdata_q <= ram_dout;
          done_a_q <= ~owner_q;
          done_b_q <= owner_q;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Address and data come straight from the command registers so the RAM
  // lines never follow the client inputs between accesses.
  assign ram_addr = cmd_addr_q;
  assign ram_din  = cmd_din_q;
  assign ram_we   = ram_we_q;
  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign done_a   = done_a_q;
  assign done_b   = done_b_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram24_arbiter.sv
// Directed bench for ram24_arbiter with a behavioural 24x4096 RAM attached.
module tb_ram24_arbiter;

  logic        clk = 1'b0;
  logic        RE;
  logic        req_a, req_b, we_a, we_b;
  logic [11:0] addr_a, addr_b;
  logic [23:0] wdata_a, wdata_b;
  logic        gnt_a, gnt_b, done_a, done_b;
  logic [23:0] rdata;
  logic [11:0] ram_addr;
  logic [23:0] ram_din;
  logic        ram_we;
  logic [23:0] ram_dout;

  logic [23:0] mem [4096];

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_rdata;

  always #5 clk = ~clk;

  // Single-port RAM: combinational read, write on the rising edge.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  ram24_arbiter #(.AW(12), .DW(24)) dut (
    .clk(clk), .RE(RE),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One uncontended command; for reads d is the expected read data.
  task automatic do_cmd(input bit is_b, input bit we, input logic [11:0] a, input logic [23:0] d);
    if (is_b) begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d; end
    else      begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d; end
    step();
    chk("cmd_gnt", {gnt_a, gnt_b}, is_b ? 2'b01 : 2'b10);
    chk("cmd_we", ram_we, we);
    chk("cmd_addr", ram_addr, a);
    if (we) chk("cmd_din", ram_din, d);
    chk("cmd_no_done_in_access", {done_a, done_b}, 2'b00);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("cmd_done", {done_a, done_b}, is_b ? 2'b01 : 2'b10);
    chk("cmd_gnt_low", {gnt_a, gnt_b}, 2'b00);
    chk("cmd_we_low", ram_we, 1'b0);
    if (!we) exp_rdata = d;
    chk("cmd_rdata", rdata, exp_rdata);
    step();
    chk("cmd_done_low", {done_a, done_b}, 2'b00);
    chk("cmd_addr_hold", ram_addr, a);
  endtask

  initial begin
    int cyc;
    int prev;
    int ngr;
    bit exp_b;

    for (int i = 0; i < 4096; i++) mem[i] = 24'h5A5A5A;

    // Reset with both clients already requesting; A's command is a write.
    RE = 1'b1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 12'h7FF; wdata_a = 24'hABCDEF;
    req_b = 1'b1; we_b = 1'b0; addr_b = 12'h000; wdata_b = 24'h0;
    exp_rdata = 24'h0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", {gnt_a, gnt_b}, 2'b00);
      chk("rst_done", {done_a, done_b}, 2'b00);
      chk("rst_we", ram_we, 1'b0);
      chk("rst_rdata", rdata, 24'h0);
      chk("rst_addr", ram_addr, 12'h000);
      chk("rst_din", ram_din, 24'h0);
    end
    RE = 1'b0;

    // First grant after reset goes to A; write 0xABCDEF to 0x7FF.
    step();
    chk("first_gnt", {gnt_a, gnt_b}, 2'b10);
    chk("wr_we", ram_we, 1'b1);
    chk("wr_addr", ram_addr, 12'h7FF);
    chk("wr_din", ram_din, 24'hABCDEF);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("wr_done", {done_a, done_b}, 2'b10);
    chk("wr_we_one_cycle", ram_we, 1'b0);
    step();
    chk("wr_done_low", {done_a, done_b}, 2'b00);

    do_cmd(1'b0, 1'b0, 12'h7FF, 24'hABCDEF);   // A reads back
    do_cmd(1'b1, 1'b1, 12'h000, 24'hFFFFFF);   // B writes low boundary

    // Contention: B was served last, so A (write) goes first, then B (read).
    req_a = 1'b1; we_a = 1'b1; addr_a = 12'h001; wdata_a = 24'h000111;
    req_b = 1'b1; we_b = 1'b0; addr_b = 12'h001; wdata_b = 24'h0;
    step();
    chk("cont_gnt_a", {gnt_a, gnt_b}, 2'b10);
    chk("cont_we_a", ram_we, 1'b1);
    req_a = 1'b0;
    step();
    chk("cont_done_a", {done_a, done_b}, 2'b10);
    step();
    chk("cont_gap1", {done_a, done_b}, 2'b00);
    step();
    chk("cont_gnt_b", {gnt_a, gnt_b}, 2'b01);
    chk("cont_addr_b", ram_addr, 12'h001);
    chk("cont_gap2", {done_a, done_b}, 2'b00);
    req_b = 1'b0;
    step();
    chk("cont_done_b", {done_a, done_b}, 2'b01);
    chk("cont_rdata_b", rdata, 24'h000111);

    // Fairness: both request reads continuously for 12 grants.
    req_a = 1'b1; we_a = 1'b0; addr_a = 12'h001;
    req_b = 1'b1; we_b = 1'b0; addr_b = 12'h001;
    cyc = 0; prev = 0; ngr = 0; exp_b = 1'b0;
    while (ngr < 12 && cyc < 60) begin
      step();
      cyc++;
      if (gnt_a || gnt_b) begin
        chk("fair_order", {gnt_a, gnt_b}, exp_b ? 2'b01 : 2'b10);
        if (ngr > 0) chk("fair_gap", cyc - prev, 3);
        prev = cyc;
        ngr++;
        exp_b = ~exp_b;
      end
    end
    chk("fair_count", ngr, 12);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("fair_last_done_b", {done_a, done_b}, 2'b01);
    chk("fair_rdata", rdata, 24'h000111);
    exp_rdata = 24'h000111;
    step();

    // Boundary addresses.
    do_cmd(1'b0, 1'b1, 12'hFFF, 24'h000000);   // A writes high boundary
    do_cmd(1'b1, 1'b0, 12'h000, 24'hFFFFFF);
    do_cmd(1'b0, 1'b0, 12'hFFF, 24'h000000);
    do_cmd(1'b0, 1'b0, 12'h001, 24'h000111);
    do_cmd(1'b1, 1'b0, 12'hFFE, 24'h5A5A5A);

    // Reset during B's read ACCESS cycle.
    req_b = 1'b1; we_b = 1'b0; addr_b = 12'h000;
    step();
    chk("mid_gnt_b", {gnt_a, gnt_b}, 2'b01);
    RE = 1'b1;
    req_b = 1'b0;
    step();
    chk("mid_no_done", {done_a, done_b}, 2'b00);
    chk("mid_gnt_low", {gnt_a, gnt_b}, 2'b00);
    chk("mid_rdata_zero", rdata, 24'h0);
    chk("mid_we_low", ram_we, 1'b0);
    RE = 1'b0;
    step();
    chk("mid_still_no_done", {done_a, done_b}, 2'b00);
    chk("mid_idle_no_gnt", {gnt_a, gnt_b}, 2'b00);
    exp_rdata = 24'h0;
    do_cmd(1'b1, 1'b0, 12'h000, 24'hFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
